// File: rtl/axi_portal_initiator_if.sv
// Bundles the command, response and AXI3-subset channels of the portal initiator.
// master = initiator side, slave = driver/responder side.
interface axi_portal_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 12
) ();
    // driver command / write data / read data / completion
    logic                  req_ena;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [3:0]            req_len;
    logic [ID_WIDTH-1:0]   req_id;
    logic                  req_rdy;
    logic                  wdata_ena;
    logic [DATA_WIDTH-1:0] wdata_v;
    logic                  wdata_rdy;
    logic                  rdata_ena;
    logic [DATA_WIDTH-1:0] rdata_v;
    logic                  rdata_last;
    logic                  rdata_rdy;
    logic                  done_ena;
    logic [ID_WIDTH-1:0]   done_id;
    logic [1:0]            done_resp;
    logic                  done_rdy;
    // AXI channels
    logic                  ar_ena;
    logic [31:0]           ar_addr;
    logic [ID_WIDTH-1:0]   ar_id;
    logic [3:0]            ar_len;
    logic                  ar_rdy;
    logic                  aw_ena;
    logic [31:0]           aw_addr;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [3:0]            aw_len;
    logic                  aw_rdy;
    logic                  w_ena;
    logic [DATA_WIDTH-1:0] w_data;
    logic [ID_WIDTH-1:0]   w_id;
    logic                  w_last;
    logic                  w_rdy;
    logic                  r_ena;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_last;
    logic [1:0]            r_resp;
    logic                  r_rdy;
    logic                  b_ena;
    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  b_rdy;

    modport master (
        input  req_ena, req_write, req_addr, req_len, req_id,
        output req_rdy,
        input  wdata_ena, wdata_v,
        output wdata_rdy,
        output rdata_ena, rdata_v, rdata_last,
        input  rdata_rdy,
        output done_ena, done_id, done_resp,
        input  done_rdy,
        output ar_ena, ar_addr, ar_id, ar_len,
        input  ar_rdy,
        output aw_ena, aw_addr, aw_id, aw_len,
        input  aw_rdy,
        output w_ena, w_data, w_id, w_last,
        input  w_rdy,
        input  r_ena, r_data, r_id, r_last, r_resp,
        output r_rdy,
        input  b_ena, b_id, b_resp,
        output b_rdy
    );

    modport slave (
        output req_ena, req_write, req_addr, req_len, req_id,
        input  req_rdy,
        output wdata_ena, wdata_v,
        input  wdata_rdy,
        input  rdata_ena, rdata_v, rdata_last,
        output rdata_rdy,
        input  done_ena, done_id, done_resp,
        output done_rdy,
        input  ar_ena, ar_addr, ar_id, ar_len,
        output ar_rdy,
        input  aw_ena, aw_addr, aw_id, aw_len,
        output aw_rdy,
        input  w_ena, w_data, w_id, w_last,
        output w_rdy,
        output r_ena, r_data, r_id, r_last, r_resp,
        input  r_rdy,
        output b_ena, b_id, b_resp,
        input  b_rdy
    );
endinterface

// File: rtl/axi_portal_initiator.sv
// Single-outstanding AXI3-subset initiator: one driver command becomes one AR/AW burst.
// Optional watchdog on RDATA/BWAIT stalls: AXI_PORTAL_INITIATOR_TIMEOUT_EN.
module axi_portal_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 12,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  CLK,
    input  logic                  nRST,
    axi_portal_initiator_if.master port,
    output logic                  error_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_RDATA, S_AW, S_WDATA, S_BWAIT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                error_q, error_d;
    logic [ID_WIDTH-1:0] bid_q, bid_d;
    logic [1:0]          bresp_q, bresp_d;

    logic in_rdata, in_wdata, r_xfer, w_xfer, r_bad;

    assign in_rdata = (state_q == S_RDATA);
    assign in_wdata = (state_q == S_WDATA);
    assign r_xfer   = in_rdata & port.r_ena & port.rdata_rdy;
    assign w_xfer   = in_wdata & port.wdata_ena & port.w_rdy;

    // Beat-count check: last must land exactly on beat len, and nothing may run past it.
    assign r_bad = (port.r_last ? (cnt_q != len_q) : (cnt_q == len_q))
                 | (port.r_resp != 2'b00) | (port.r_id != id_q);

`ifdef AXI_PORTAL_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wdog_q, wdog_d;
    logic        stall;

    assign stall = (in_rdata & ~r_xfer) | ((state_q == S_BWAIT) & ~port.b_ena);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        bid_d   = bid_q;
        bresp_d = bresp_q;
        unique case (state_q)
            S_IDLE: if (port.req_ena) begin
                addr_d  = port.req_addr;
                id_d    = port.req_id;
                len_d   = port.req_len;
                cnt_d   = '0;
                state_d = port.req_write ? S_AW : S_AR;
            end
            S_AR:    if (port.ar_rdy) state_d = S_RDATA;
            S_RDATA: if (r_xfer) begin
                cnt_d = cnt_q + 4'd1;
                if (r_bad) error_d = 1'b1;
                if (port.r_last) state_d = S_IDLE;
            end
            S_AW:    if (port.aw_rdy) state_d = S_WDATA;
            S_WDATA: if (w_xfer) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == len_q) state_d = S_BWAIT;
            end
            S_BWAIT: if (port.b_ena) begin
                bid_d   = port.b_id;
                bresp_d = port.b_resp;
                if ((port.b_resp != 2'b00) || (port.b_id != id_q)) error_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  if (port.done_rdy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef AXI_PORTAL_INITIATOR_TIMEOUT_EN
        wdog_d = '0;
        if (stall) begin
            if (wdog_q == WDOG_LAST) begin
                // Give up: a missing B is reported as SLVERR, a stuck read is dropped.
                error_d = 1'b1;
                if (state_q == S_BWAIT) begin
                    bid_d   = id_q;
                    bresp_d = 2'b10;
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                wdog_d = wdog_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            bid_q   <= '0;
            bresp_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            bid_q   <= bid_d;
            bresp_q <= bresp_d;
        end
    end

`ifdef AXI_PORTAL_INITIATOR_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!nRST) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end
`endif

    assign port.req_rdy    = (state_q == S_IDLE);

    assign port.ar_ena     = (state_q == S_AR);
    assign port.ar_addr    = addr_q;
    assign port.ar_id      = id_q;
    assign port.ar_len     = len_q;
    assign port.aw_ena     = (state_q == S_AW);
    assign port.aw_addr    = addr_q;
    assign port.aw_id      = id_q;
    assign port.aw_len     = len_q;

    // Write beats pass straight through so the driver sees W backpressure in the same cycle.
    assign port.wdata_rdy  = in_wdata & port.w_rdy;
    assign port.w_ena      = in_wdata & port.wdata_ena;
    assign port.w_data     = port.wdata_v;
    assign port.w_id       = id_q;
    assign port.w_last     = in_wdata & (cnt_q == len_q);

    assign port.r_rdy      = in_rdata & port.rdata_rdy;
    assign port.rdata_ena  = in_rdata & port.r_ena;
    assign port.rdata_v    = port.r_data;
    assign port.rdata_last = port.r_last;

    assign port.b_rdy      = (state_q == S_BWAIT);
    assign port.done_ena   = (state_q == S_DONE);
    assign port.done_id    = bid_q;
    assign port.done_resp  = bresp_q;

    assign error_o = error_q;
endmodule

// File: tb/tb_axi_portal_initiator.sv
// Randomized bench for axi_portal_initiator: the bench plays both driver and AXI responder
// and predicts data, handshakes and the sticky error flag from the transaction-level rules.
module tb_axi_portal_initiator;
    localparam int DW   = 32;
    localparam int ID_W = 12;

    logic clk = 1'b0;
    logic nrst;
    logic err;
    int   n_chk = 0;
    int   n_bad = 0;
    logic err_exp;

    always #5 clk = ~clk;

    axi_portal_initiator_if #(.DATA_WIDTH(DW), .ID_WIDTH(ID_W)) bus ();

    axi_portal_initiator #(.DATA_WIDTH(DW), .ID_WIDTH(ID_W), .TIMEOUT(16)) dut (
        .CLK(clk), .nRST(nrst), .port(bus.master), .error_o(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.req_ena = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_len = '0; bus.req_id = '0;
        bus.wdata_ena = 0; bus.wdata_v = '0; bus.rdata_rdy = 0; bus.done_rdy = 0;
        bus.ar_rdy = 0; bus.aw_rdy = 0; bus.w_rdy = 0;
        bus.r_ena = 0; bus.r_data = '0; bus.r_id = '0; bus.r_last = 0; bus.r_resp = '0;
        bus.b_ena = 0; bus.b_id = '0; bus.b_resp = '0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req_rdy"}, 64'(bus.req_rdy), 64'(1));
        chk({tag, "_enas"}, 64'({bus.ar_ena, bus.aw_ena, bus.w_ena, bus.rdata_ena, bus.done_ena}), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(err_exp));
    endtask

    // Presents one command; returns at the negedge after acceptance.
    task automatic start_req(input logic wr, input logic [31:0] a, input logic [ID_W-1:0] id,
                             input logic [3:0] len);
        int g = 0;
        while (bus.req_rdy !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        chk("req_rdy", 64'(bus.req_rdy), 64'(1));
        bus.req_ena = 1; bus.req_write = wr; bus.req_addr = a; bus.req_id = id; bus.req_len = len;
        @(negedge clk);
        // scramble the command bus so a missing latch shows up on AR/AW
        bus.req_ena = 0; bus.req_addr = ~a; bus.req_id = ~id; bus.req_len = ~len;
    endtask

    task automatic rd_txn(input logic [31:0] a, input logic [ID_W-1:0] id, input logic [3:0] len,
                          input int nb, input int bad, input int badk, input int arw,
                          input logic [31:0] d0);
        int i, g;
        logic pend;
        logic [31:0] d;
        logic [ID_W-1:0] rid;
        logic [1:0] rsp;
        start_req(1'b0, a, id, len);
        for (int k = 0; k <= arw; k++) begin
            bus.ar_rdy = (k == arw);
            bus.b_ena = 1; bus.b_id = ID_W'($urandom);
            #1;
            chk("ar_ena", 64'(bus.ar_ena), 64'(1));
            chk("ar_addr", 64'(bus.ar_addr), 64'(a));
            chk("ar_id", 64'(bus.ar_id), 64'(id));
            chk("ar_len", 64'(bus.ar_len), 64'(len));
            chk("b_ignored", 64'(bus.b_rdy), 64'(0));
            chk("rd_no_beat", 64'(bus.rdata_ena), 64'(0));
            @(negedge clk);
        end
        bus.ar_rdy = 0; bus.b_ena = 0;
        i = 0; g = 0; pend = 0;
        d = d0; rid = (bad == 0 && badk == 1) ? id ^ 1 : id; rsp = (bad == 0 && badk == 0) ? 2'b10 : 2'b00;
        while (i < nb && g < 300) begin
            if (!pend) bus.r_ena = ($urandom_range(0, 3) != 0);
            bus.r_data = d; bus.r_id = rid; bus.r_resp = rsp; bus.r_last = (i == nb - 1);
            bus.rdata_rdy = ($urandom_range(0, 2) != 0);
            #1;
            chk("r_rdy", 64'(bus.r_rdy), 64'(bus.rdata_rdy));
            chk("rdata_ena", 64'(bus.rdata_ena), 64'(bus.r_ena));
            if (bus.r_ena) begin
                chk("rdata_v", 64'(bus.rdata_v), 64'(d));
                chk("rdata_last", 64'(bus.rdata_last), 64'(i == nb - 1));
            end
            if (bus.r_ena && bus.rdata_rdy) begin
                if (rsp != 2'b00 || rid != id) err_exp = 1'b1;
                i++; pend = 0;
                d = $urandom;
                rid = (bad == i && badk == 1) ? id ^ 1 : id;
                rsp = (bad == i && badk == 0) ? 2'b10 : 2'b00;
            end else begin
                pend = bus.r_ena;
            end
            @(negedge clk); g++;
        end
        chk("rd_beats", 64'(i), 64'(nb));
        bus.r_ena = 0; bus.rdata_rdy = 0; bus.r_last = 0;
        if (nb != int'(len) + 1) err_exp = 1'b1;
        #1;
        check_quiet("rd_end");
    endtask

    task automatic wr_txn(input logic [31:0] a, input logic [ID_W-1:0] id, input logic [3:0] len,
                          input int arw, input logic [ID_W-1:0] bid, input logic [1:0] brsp,
                          input int abort, input bit no_b, input bit seq);
        int i, g, k;
        logic pend;
        logic [31:0] cur;
        start_req(1'b1, a, id, len);
        for (int j = 0; j <= arw; j++) begin
            bus.aw_rdy = (j == arw);
            bus.wdata_ena = 1; bus.wdata_v = $urandom;
            bus.b_ena = 1; bus.b_id = id;
            #1;
            chk("aw_ena", 64'(bus.aw_ena), 64'(1));
            chk("aw_addr", 64'(bus.aw_addr), 64'(a));
            chk("aw_id", 64'(bus.aw_id), 64'(id));
            chk("aw_len", 64'(bus.aw_len), 64'(len));
            chk("w_before_aw", 64'({bus.w_ena, bus.wdata_rdy}), 64'(0));
            chk("b_ignored", 64'(bus.b_rdy), 64'(0));
            @(negedge clk);
        end
        bus.aw_rdy = 0; bus.b_ena = 0; bus.wdata_ena = 0;
        i = 0; g = 0; pend = 0;
        cur = seq ? 32'd1 : $urandom;
        while (i <= int'(len) && g < 300) begin
            if (abort == i) begin
                bus.wdata_ena = 0; bus.w_rdy = 0; nrst = 0;
                @(negedge clk);
                nrst = 1; err_exp = 1'b0;
                #1;
                check_quiet("rst_mid");
                for (int r = 0; r < 4; r++) begin
                    @(negedge clk); #1;
                    chk("rst_no_done", 64'(bus.done_ena), 64'(0));
                end
                return;
            end
            if (!pend) bus.wdata_ena = seq ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.wdata_v = cur;
            bus.w_rdy = seq ? g[0] : ($urandom_range(0, 1) == 1);
            #1;
            chk("w_ena", 64'(bus.w_ena), 64'(bus.wdata_ena));
            chk("wdata_rdy", 64'(bus.wdata_rdy), 64'(bus.w_rdy));
            if (bus.wdata_ena) begin
                chk("w_data", 64'(bus.w_data), 64'(cur));
                chk("w_id", 64'(bus.w_id), 64'(id));
                chk("w_last", 64'(bus.w_last), 64'(i == int'(len)));
            end
            if (bus.wdata_ena && bus.w_rdy) begin
                i++; pend = 0;
                cur = seq ? 32'(i + 1) : $urandom;
            end else begin
                pend = bus.wdata_ena;
            end
            @(negedge clk); g++;
        end
        chk("wr_beats", 64'(i), 64'(int'(len) + 1));
        bus.wdata_ena = 0; bus.w_rdy = 0;
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin
            #1;
            chk("b_rdy_wait", 64'(bus.b_rdy), 64'(1));
            chk("no_early_done", 64'(bus.done_ena), 64'(0));
            @(negedge clk);
        end
        if (no_b) return;
        bus.b_ena = 1; bus.b_id = bid; bus.b_resp = brsp;
        #1;
        chk("b_rdy", 64'(bus.b_rdy), 64'(1));
        @(negedge clk);
        bus.b_ena = 0;
        if (brsp != 2'b00 || bid != id) err_exp = 1'b1;
        k = $urandom_range(0, 3);
        for (int j = 0; j <= k; j++) begin
            bus.done_rdy = (j == k);
            #1;
            chk("done_ena", 64'(bus.done_ena), 64'(1));
            chk("done_id", 64'(bus.done_id), 64'(bid));
            chk("done_resp", 64'(bus.done_resp), 64'(brsp));
            @(negedge clk);
        end
        bus.done_rdy = 0;
        #1;
        check_quiet("wr_end");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] len;
        logic [ID_W-1:0] id;
        int nb;
        idle_inputs();
        err_exp = 1'b0;
        nrst = 0;
        repeat (3) @(negedge clk);
        nrst = 1;
        #1;
        check_quiet("reset");
        chk("reset_b_rdy", 64'(bus.b_rdy), 64'(0));

        // len=0 read of 0xDEADBEEF
        rd_txn(32'h10, 12'd5, 4'd0, 1, -1, 0, 0, 32'hDEADBEEF);
        // len=3 write, data 1..4, W__RDY toggling, B id 7
        wr_txn(32'h200, 12'd7, 4'd3, 1, 12'd7, 2'b00, -1, 1'b0, 1'b1);
        // AR held off for 10 cycles
        rd_txn(32'h3000, 12'h2a, 4'd3, 4, -1, 0, 10, $urandom);
        // len=15 boundary, both directions
        rd_txn($urandom, 12'h0f0, 4'd15, 16, -1, 0, 0, $urandom);
        wr_txn($urandom, 12'h0f1, 4'd15, 0, 12'h0f1, 2'b00, -1, 1'b0, 1'b0);

        // clean random traffic: error must stay low
        for (int t = 0; t < 20; t++) begin
            len = 4'($urandom); id = ID_W'($urandom);
            if ($urandom_range(0, 1) == 1)
                rd_txn($urandom, id, len, int'(len) + 1, -1, 0, $urandom_range(0, 3), $urandom);
            else
                wr_txn($urandom, id, len, $urandom_range(0, 3), id, 2'b00, -1, 1'b0, 1'b0);
        end

        // early last on beat 2 of a len=3 read
        rd_txn(32'h40, 12'd9, 4'd3, 3, -1, 0, 0, $urandom);
        chk("early_last_err", 64'(err), 64'(1));

        // reset mid-write after 2 of 4 beats clears the sticky error
        wr_txn(32'h80, 12'd3, 4'd3, 0, 12'd3, 2'b00, 2, 1'b0, 1'b0);

        // random traffic with injected faults
        for (int t = 0; t < 12; t++) begin
            len = 4'($urandom_range(0, 14)); id = ID_W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                nb = int'(len) + 1;
                if ($urandom_range(0, 2) == 0) nb = $urandom_range(1, int'(len) + 2);
                rd_txn($urandom, id, len, nb, $urandom_range(0, nb), $urandom_range(0, 1),
                       $urandom_range(0, 2), $urandom);
            end else begin
                wr_txn($urandom, id, len, $urandom_range(0, 2),
                       ($urandom_range(0, 2) == 0) ? id ^ 1 : id, 2'($urandom_range(0, 3)),
                       -1, 1'b0, 1'b0);
            end
        end

`ifdef AXI_PORTAL_INITIATOR_TIMEOUT_EN
        begin
            int g = 0;
            nrst = 0; @(negedge clk); nrst = 1; err_exp = 1'b0;
            wr_txn(32'h500, 12'd4, 4'd1, 0, 12'd4, 2'b00, -1, 1'b1, 1'b0);
            while (bus.done_ena !== 1'b1 && g < 40) begin @(negedge clk); g++; end
            chk("to_done", 64'(bus.done_ena), 64'(1));
            chk("to_resp", 64'(bus.done_resp), 64'(2));
            chk("to_err", 64'(err), 64'(1));
            bus.done_rdy = 1; @(negedge clk); bus.done_rdy = 0;
        end
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
